tl_uh_mem_slave: RTL and testbench
==================================

# tl_uh_mem_slave

Synthesizable TL-UH memory slave that terminates the L2 cache's memory port (`mem_a_*`/`mem_d_*`) in system-level benches. It replaces ad-hoc memory behaviour in `stimulus`. It accepts Get and PutFullData/PutPartialData on channel A, stores data in a byte-maskable word array, and returns AccessAckData/AccessAck on channel D. Response latency is configurable and D-channel back-pressure is honoured. Only one transaction is in flight at a time.

## Interface
- `ADDR_W`, 64: address width.
- `DATA_W`, 64: beat width; fixed 8 bytes per beat.
- `SOURCE_W`, 4: source ID width.
- `SINK_W`, 2: sink ID width; `d_sink` always 0.
- `MEM_WORDS`, 4096: array depth in DATA_W words; power of two.
- `LATENCY`, 4: cycles between the last A beat and the first D beat, minus one; 0 is legal.

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `a_opcode_i` in 3, `a_param_i` in 3, `a_size_i` in 3 (log2 bytes), `a_source_i` in SOURCE_W, `a_address_i` in ADDR_W, `a_mask_i` in 8, `a_data_i` in DATA_W, `a_valid_i` in 1.
- `a_ready_o` out 1: A beat accepted when `a_valid_i && a_ready_o`.
- `d_opcode_o` out 3, `d_param_o` out 2 (always 0), `d_size_o` out 3, `d_source_o` out SOURCE_W, `d_sink_o` out SINK_W, `d_denied_o` out 1, `d_data_o` out DATA_W, `d_corrupt_o` out 1, `d_valid_o` out 1.
- `d_ready_i` in 1: D beat consumed when `d_valid_o && d_ready_i`.

## Operation
- Opcodes:
  - A channel: PutFullData=0, PutPartialData=1, Get=4.
  - D channel: AccessAck=0, AccessAckData=1.
- Beats per message: `beats = (a_size_i <= 3) ? 1 : 1 << (a_size_i-3)`. Sizes above 6 are an error.
- Word index = `a_address_i[3 +: log2(MEM_WORDS)] + beat`.
- Error cases:
  - address not aligned to `2^a_size`;
  - `a_address_i >= MEM_WORDS*8`;
  - size > 6;
  - unsupported opcode.
- Error responses:
  - Put: no array write, single AccessAck with `d_denied_o=1`.
  - Get: all beats return `d_denied_o=1`, `d_corrupt_o=1`, data 0.
  - Any other opcode: single AccessAck, denied.
- FSM states: IDLE, WRITE, WAIT, RESP.
  - IDLE (`a_ready_o=1`): first beat fire latches opcode/size/source/address and the error flag.
    - Get: go to WAIT, or to RESP if LATENCY=0.
    - Put: write beat 0 with `a_mask_i`. If beats==1, go to WAIT/RESP; else go to WRITE.
  - WRITE (`a_ready_o=1`): each fire writes the next word with its mask. Address/size/opcode of later beats are ignored. After the last beat, go to WAIT/RESP.
  - WAIT (`a_ready_o=0`): counter loads LATENCY-1 and decrements; at 0, go to RESP.
  - RESP (`a_ready_o=0`, `d_valid_o=1`):
    - Get emits `beats` AccessAckData beats; `d_data_o = mem[index+beat]`.
    - Put emits one AccessAck with `d_data_o=0`.
    - `d_size_o` and `d_source_o` echo the request.
    - Beat counter advances only on D fire. The last fire goes to IDLE.
- D outputs stay stable while `d_valid_o && !d_ready_i`.
- Array read is asynchronous in the indexed beat.

## Timing
- Reset values: `a_ready_o=0` during reset and 1 in the first cycle after reset. All `d_*` outputs 0. State IDLE, counters 0.
- Array contents are not reset.
- Last A fire at cycle t → first `d_valid_o` at cycle t+1+LATENCY.
- With `d_ready_i` held high, Get beats are on consecutive cycles.
- After the last D fire at cycle u, `a_ready_o=1` at cycle u+1. There is no A/D overlap.
- Reset asserted mid-transaction drops it: the next cycle is IDLE, `d_valid_o=0`, and any partial burst already written stays written.
- A valid low in WRITE: wait indefinitely; the beat counter holds.

## Structure
- `tl_uh_pkg` holds:
  - opcode localparams (`TL_GET`, `TL_PUT_FULL`, `TL_PUT_PARTIAL`, `TL_ACCESS_ACK`, `TL_ACCESS_ACK_DATA`);
  - the FSM state enum;
  - the `beats_from_size` function.
- One sub-module, `tl_uh_mem_array`: MEM_WORDS×64 storage, one byte-masked synchronous write port, one asynchronous read port.

## Test plan
- Put then Get, 8 bytes: PutFullData size 3, address 0x40, data 0xDEADBEEF_CAFEF00D, mask 0xFF → AccessAck at t+5 (LATENCY=4). Get of 0x40 → AccessAckData with the same data, `d_source_o` echoed.
- Burst: PutFullData size 6 to 0x100, beats k=0..7 carrying data k → one AccessAck. Get size 6 → 8 beats on consecutive cycles, data 0..7.
- Partial write: PutPartialData mask 0x0F, data 0x11111111_22222222 over a word of all-ones → readback 0xFFFFFFFF_22222222.
- Back-pressure: Get size 6 with `d_ready_i` toggled every cycle → exactly 8 fires, data held stable across stalls, `a_ready_o=0` until the last fire.
- Errors:
  - Get at address MEM_WORDS*8 → denied=1, corrupt=1.
  - Put size 6 to 0x108 (misaligned) → denied AccessAck, array unchanged.
- Reset mid-RESP after 3 of 8 beats → `d_valid_o=0` next cycle. A new Get completes normally.

Source files
------------

// File: rtl/tl_uh_mem_slave_pkg.sv
// tl_uh_pkg: TileLink opcodes, FSM state type and burst-length helper for the memory slave
package tl_uh_pkg;
  localparam logic [2:0] TL_PUT_FULL = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] TL_GET = 3'd4;
  localparam logic [2:0] TL_ACCESS_ACK = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;
  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_e;
  function automatic logic [3:0] beats_from_size(input logic [2:0] size);
    return (size <= 3'd3 || size > 3'd6) ? 4'd1 : 4'd1 << (size - 3'd3);
  endfunction
endpackage

// File: rtl/tl_uh_mem_slave_if.sv
// tl_uh_mem_slave_if: TL-UH A/D channel bundle with master and slave views
interface tl_uh_mem_slave_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int SOURCE_W = 4,
  parameter int SINK_W = 2
);
  logic [2:0] a_opcode_i;
  logic [2:0] a_param_i;
  logic [2:0] a_size_i;
  logic [SOURCE_W-1:0] a_source_i;
  logic [ADDR_W-1:0] a_address_i;
  logic [7:0] a_mask_i;
  logic [DATA_W-1:0] a_data_i;
  logic a_valid_i;
  logic a_ready_o;
  logic [2:0] d_opcode_o;
  logic [1:0] d_param_o;
  logic [2:0] d_size_o;
  logic [SOURCE_W-1:0] d_source_o;
  logic [SINK_W-1:0] d_sink_o;
  logic d_denied_o;
  logic [DATA_W-1:0] d_data_o;
  logic d_corrupt_o;
  logic d_valid_o;
  logic d_ready_i;
  modport slave (
    input a_opcode_i, a_param_i, a_size_i, a_source_i, a_address_i, a_mask_i, a_data_i, a_valid_i, d_ready_i,
    output a_ready_o, d_opcode_o, d_param_o, d_size_o, d_source_o, d_sink_o, d_denied_o, d_data_o, d_corrupt_o, d_valid_o
  );
  modport master (
    output a_opcode_i, a_param_i, a_size_i, a_source_i, a_address_i, a_mask_i, a_data_i, a_valid_i, d_ready_i,
    input a_ready_o, d_opcode_o, d_param_o, d_size_o, d_source_o, d_sink_o, d_denied_o, d_data_o, d_corrupt_o, d_valid_o
  );
endinterface

// File: rtl/tl_uh_mem_array.sv
// tl_uh_mem_array: word array with one byte-masked synchronous write port and one asynchronous read port
module tl_uh_mem_array #(
  parameter int WORDS = 4096,
  parameter int AW = $clog2(WORDS)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wmask_i,
  input  logic [63:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [63:0]   rdata_o
);
  logic [63:0] mem_q [WORDS];
  // byte lanes enabled by the mask are updated; contents are never reset
  always_ff @(posedge clk_i)
    if (we_i)
      for (int b = 0; b < 8; b++)
        if (wmask_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/tl_uh_mem_slave.sv
// tl_uh_mem_slave: single-outstanding TL-UH memory slave with configurable response latency
module tl_uh_mem_slave
  import tl_uh_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int SOURCE_W = 4,
  parameter int SINK_W = 2,
  parameter int MEM_WORDS = 4096,
  parameter int LATENCY = 4
) (
  input logic clk_i,
  input logic rst_i,
  tl_uh_mem_slave_if.slave bus
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(LATENCY + 1) + 1;
  state_e state_q, state_d;
  logic [2:0] op_q, op_d, size_q, size_d;
  logic [SOURCE_W-1:0] src_q, src_d;
  logic [AW-1:0] idx_q, idx_d;
  logic err_q, err_d;
  logic [3:0] beat_q, beat_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic idle, a_fire, d_fire, a_err, err_c, is_put_c, is_get_q, last_a, last_d, we;
  logic [2:0] op_c, size_c;
  logic [3:0] nb_c, d_beats;
  logic [AW-1:0] wr_idx, rd_idx;
  logic [63:0] rdata;
  logic unused;
  state_e after_a;
  assign unused = ^bus.a_param_i;
  assign idle = state_q == IDLE;
  assign a_fire = bus.a_valid_i && bus.a_ready_o;
  assign d_fire = bus.d_valid_o && bus.d_ready_i;
  assign a_err = bus.a_size_i > 3'd6
              || (bus.a_address_i[5:0] & ((6'd1 << bus.a_size_i) - 6'd1)) != 6'd0
              || bus.a_address_i[ADDR_W-1:AW+3] != '0
              || !(bus.a_opcode_i == TL_PUT_FULL || bus.a_opcode_i == TL_PUT_PARTIAL || bus.a_opcode_i == TL_GET);
  assign op_c = idle ? bus.a_opcode_i : op_q;
  assign size_c = idle ? bus.a_size_i : size_q;
  assign err_c = idle ? a_err : err_q;
  assign is_put_c = op_c == TL_PUT_FULL || op_c == TL_PUT_PARTIAL;
  assign is_get_q = op_q == TL_GET;
  assign nb_c = is_put_c ? beats_from_size(size_c) : 4'd1;
  assign d_beats = is_get_q ? beats_from_size(size_q) : 4'd1;
  assign last_a = beat_q == nb_c - 4'd1;
  assign last_d = beat_q == d_beats - 4'd1;
  assign wr_idx = (idle ? bus.a_address_i[3 +: AW] : idx_q) + AW'(beat_q);
  assign rd_idx = idx_q + AW'(beat_q);
  assign we = a_fire && is_put_c && !err_c;
  assign after_a = LATENCY == 0 ? RESP : WAIT;
  tl_uh_mem_array #(.WORDS(MEM_WORDS), .AW(AW)) u_array (
    .clk_i  (clk_i),
    .we_i   (we),
    .waddr_i(wr_idx),
    .wmask_i(bus.a_mask_i),
    .wdata_i(64'(bus.a_data_i)),
    .raddr_i(rd_idx),
    .rdata_o(rdata)
  );
  assign bus.a_ready_o = !rst_i && (idle || state_q == WRITE);
  assign bus.d_valid_o = state_q == RESP;
  assign bus.d_opcode_o = bus.d_valid_o && is_get_q ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
  assign bus.d_param_o = '0;
  assign bus.d_size_o = bus.d_valid_o ? size_q : '0;
  assign bus.d_source_o = bus.d_valid_o ? src_q : '0;
  assign bus.d_sink_o = '0;
  assign bus.d_denied_o = bus.d_valid_o && err_q;
  assign bus.d_corrupt_o = bus.d_valid_o && err_q && is_get_q;
  assign bus.d_data_o = bus.d_valid_o && is_get_q && !err_q ? DATA_W'(rdata) : '0;
  // latch the request on its first beat, then walk A beats, the latency wait and D beats
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    size_d = size_q;
    src_d = src_q;
    idx_d = idx_q;
    err_d = err_q;
    beat_d = beat_q;
    cnt_d = cnt_q;
    if (idle && a_fire) begin
      op_d = bus.a_opcode_i;
      size_d = bus.a_size_i;
      src_d = bus.a_source_i;
      idx_d = bus.a_address_i[3 +: AW];
      err_d = a_err;
    end
    if (a_fire) begin
      state_d = last_a ? after_a : WRITE;
      beat_d = last_a ? 4'd0 : beat_q + 4'd1;
      cnt_d = CW'(LATENCY - 1);
    end
    if (state_q == WAIT) begin
      state_d = cnt_q == '0 ? RESP : WAIT;
      cnt_d = cnt_q == '0 ? cnt_q : cnt_q - CW'(1);
    end
    if (d_fire) begin
      state_d = last_d ? IDLE : RESP;
      beat_d = last_d ? 4'd0 : beat_q + 4'd1;
    end
  end
  // state registers; reset abandons any transaction in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q <= '0;
      size_q <= '0;
      src_q <= '0;
      idx_q <= '0;
      err_q <= 1'b0;
      beat_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      size_q <= size_d;
      src_q <= src_d;
      idx_q <= idx_d;
      err_q <= err_d;
      beat_q <= beat_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_tl_uh_mem_slave.sv
// tb_tl_uh_mem_slave: directed and randomized checks of the memory slave against a byte-array model
module tb_tl_uh_mem_slave;
  localparam int LAT = 4;
  localparam int MW = 4096;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int t_fire = 0;
  logic [63:0] mem_m [MW];
  logic [63:0] exp_d [8];
  logic [63:0] wd [8];
  logic [7:0] wm [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tl_uh_mem_slave_if bus ();
  tl_uh_mem_slave #(.MEM_WORDS(MW), .LATENCY(LAT)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  task automatic chk(input string n, input logic [63:0] g, input logic [63:0] e);
    tests++;
    assert (g === e) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", n, g, e);
    end
  endtask

  function automatic int nbeats(input int s);
    return s <= 3 ? 1 : 1 << (s - 3);
  endfunction

  function automatic bit is_err(input int op, input int s, input logic [63:0] a);
    return s > 6 || (a % (64'd1 << s)) != 0 || a >= 64'(MW * 8) || !(op == 0 || op == 1 || op == 4);
  endfunction

  task automatic a_beat(input int op, input int s, input logic [63:0] a, input logic [7:0] m, input logic [63:0] d, input int src);
    int n = 0;
    bus.a_opcode_i = 3'(op);
    bus.a_size_i = 3'(s);
    bus.a_address_i = a;
    bus.a_mask_i = m;
    bus.a_data_i = d;
    bus.a_source_i = 4'(src);
    bus.a_param_i = 3'($urandom);
    bus.a_valid_i = 1'b1;
    @(negedge clk);
    while (!bus.a_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("a_ready_timeout", 64'(n), 0);
    t_fire = cyc;
    @(posedge clk);
    #1 bus.a_valid_i = 1'b0;
  endtask

  // mode 0: d_ready high, 1: toggles each cycle from low, 2: random
  task automatic d_collect(input int n, input int op, input int s, input int src, input bit den, input bit cor, input int mode, input int stop);
    int k = 0;
    int w = 0;
    bit first = 1'b1;
    bit stalled = 1'b0;
    logic [63:0] held = '0;
    bus.d_ready_i = mode == 0 ? 1'b1 : mode == 1 ? 1'b0 : 1'($urandom);
    while (k < stop && w < 200) begin
      @(negedge clk);
      w++;
      if (bus.d_valid_o) begin
        if (first) chk("d_latency", 64'(cyc), 64'(t_fire + 1 + LAT));
        first = 1'b0;
        if (stalled) chk("d_stable", bus.d_data_o, held);
        chk("d_data", bus.d_data_o, exp_d[k]);
        chk("d_opcode", 64'(bus.d_opcode_o), 64'(op));
        chk("d_size", 64'(bus.d_size_o), 64'(s));
        chk("d_source", 64'(bus.d_source_o), 64'(src));
        chk("d_denied", 64'(bus.d_denied_o), 64'(den));
        chk("d_corrupt", 64'(bus.d_corrupt_o), 64'(cor));
        chk("d_param_sink", 64'({bus.d_param_o, bus.d_sink_o}), 0);
        chk("a_ready_in_resp", 64'(bus.a_ready_o), 0);
        held = bus.d_data_o;
        stalled = !bus.d_ready_i;
        if (bus.d_ready_i) k++;
      end
      @(posedge clk);
      #1 bus.d_ready_i = mode == 0 ? 1'b1 : mode == 1 ? !bus.d_ready_i : 1'($urandom);
    end
    if (w >= 200) chk("d_timeout", 64'(w), 0);
    if (stop >= n) begin
      @(negedge clk);
      chk("a_ready_after_resp", 64'(bus.a_ready_o), 1);
      chk("d_valid_after_resp", 64'(bus.d_valid_o), 0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put(input int op, input int s, input logic [63:0] a, input int src);
    bit e = is_err(op, s, a);
    int nb = (op == 0 || op == 1) ? nbeats(s) : 1;
    for (int k = 0; k < nb; k++) a_beat(op, s, a, wm[k], wd[k], src);
    if (!e)
      for (int k = 0; k < nb; k++) begin
        int w = int'(((a >> 3) + 64'(k)) % MW);
        for (int b = 0; b < 8; b++) if (wm[k][b]) mem_m[w][8*b +: 8] = wd[k][8*b +: 8];
      end
    exp_d[0] = '0;
    d_collect(1, 0, s, src, e, 1'b0, 0, 1);
  endtask

  task automatic get(input int s, input logic [63:0] a, input int src, input int mode, input int stop);
    bit e = is_err(4, s, a);
    int nb = nbeats(s);
    for (int k = 0; k < nb; k++) exp_d[k] = e ? 64'd0 : mem_m[int'(((a >> 3) + 64'(k)) % MW)];
    a_beat(4, s, a, 8'hFF, '0, src);
    d_collect(nb, 1, s, src, e, e, mode, stop);
  endtask

  task automatic fill(input logic [63:0] base, input bit inc);
    for (int k = 0; k < 8; k++) begin
      wd[k] = inc ? 64'(k) : {$urandom, $urandom};
      wm[k] = 8'hFF;
    end
  endtask

  initial begin
    bus.a_opcode_i = '0;
    bus.a_param_i = '0;
    bus.a_size_i = '0;
    bus.a_source_i = '0;
    bus.a_address_i = '0;
    bus.a_mask_i = '0;
    bus.a_data_i = '0;
    bus.a_valid_i = 1'b0;
    bus.d_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_ready", 64'(bus.a_ready_o), 0);
    chk("rst_d_valid", 64'(bus.d_valid_o), 0);
    chk("rst_d_fields", {bus.d_data_o[59:0], bus.d_denied_o, bus.d_corrupt_o, bus.d_opcode_o != 0, bus.d_size_o != 0}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_a_ready", 64'(bus.a_ready_o), 1);
    @(posedge clk);
    #1;
    for (int b = 0; b < 8; b++) begin
      fill(0, 1'b0);
      put(0, 6, 64'(b * 64), b);
    end
    wd[0] = 64'hDEADBEEF_CAFEF00D;
    wm[0] = 8'hFF;
    put(0, 3, 64'h40, 5);
    get(3, 64'h40, 9, 0, 1);
    fill(0, 1'b1);
    put(0, 6, 64'h100, 2);
    get(6, 64'h100, 3, 0, 8);
    wd[0] = '1;
    put(0, 3, 64'h80, 1);
    wd[0] = 64'h11111111_22222222;
    wm[0] = 8'h0F;
    put(1, 3, 64'h80, 1);
    get(3, 64'h80, 4, 0, 1);
    get(6, 64'h100, 6, 1, 8);
    get(3, 64'(MW * 8), 7, 0, 1);
    fill(0, 1'b0);
    put(0, 6, 64'h108, 8);
    get(6, 64'h100, 10, 0, 8);
    wd[0] = '0;
    wm[0] = 8'hFF;
    put(2, 3, 64'h40, 11);
    get(3, 64'h40, 12, 0, 1);
    get(6, 64'h100, 13, 0, 3);
    rst = 1'b1;
    bus.d_ready_i = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_d_valid", 64'(bus.d_valid_o), 0);
    chk("mid_rst_a_ready", 64'(bus.a_ready_o), 1);
    @(posedge clk);
    #1;
    get(6, 64'h100, 14, 0, 8);
    for (int i = 0; i < 40; i++) begin
      int s = int'($urandom_range(0, 6));
      int op = int'($urandom_range(0, 2));
      int r = int'($urandom_range(0, 9));
      logic [63:0] a = 64'($urandom_range(0, 511)) & ~((64'd1 << s) - 64'd1);
      if (r == 0 && s > 0) a = a | 64'd1;
      if (r == 1) a = a + 64'(MW * 8);
      if (op == 2) get(s, a, int'($urandom_range(0, 15)), int'($urandom_range(0, 2)), nbeats(s));
      else begin
        for (int k = 0; k < 8; k++) begin
          wd[k] = {$urandom, $urandom};
          wm[k] = op == 0 ? 8'hFF : 8'($urandom);
        end
        put(op, s, a, int'($urandom_range(0, 15)));
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
